fp_div_seq: RTL and testbench

Iterative IEEE-754 single-precision floating-point divider, the inverse companion of the pipelined floating-point multiplier. It computes z = a / b with a restoring radix-2 mantissa divider, one quotient bit per cycle. It uses the same rounding-mode set and the same 8-bit status layout as the multiplier. A start/busy/done handshake lets it share the datapath front end and bench infrastructure with the multiplier.

---
 rtl/fp_div_seq.sv | 214 +++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative IEEE-754 single-precision divider, z = a / b.
// Restoring radix-2 mantissa division producing one quotient bit per cycle,
// 26 iterations (24 mantissa bits + guard + round), then a rounding cycle.
// Denormal inputs are read as signed zero and no denormals are produced.

package fp_div_pkg;
  typedef enum logic [2:0] {
    IEEE_near,  // nearest, ties to even
    IEEE_zero,  // toward zero
    IEEE_pinf,  // toward +inf
    IEEE_ninf,  // toward -inf
    near_up,    // nearest, ties toward +inf
    away_zero   // away from zero
  } round_values;
endpackage

module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter round_values ROUND = IEEE_near
) (
  input  logic        clk,
  input  logic        rst,      // asynchronous, active-low
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] z,
  output logic [7:0]  status    // {0, dbz, inexact, huge, tiny, nan, inf, zero}
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;

  // Special-case outcome decided at accept time; the quotient is ignored then.
  localparam logic [2:0] SP_NONE = 3'd0;
  localparam logic [2:0] SP_NAN  = 3'd1;
  localparam logic [2:0] SP_DBZ  = 3'd2;
  localparam logic [2:0] SP_INF  = 3'd3;
  localparam logic [2:0] SP_ZERO = 3'd4;

  logic [1:0]        r_state;
  logic [4:0]        r_cnt;
  logic [24:0]       r_rem;
  logic [23:0]       r_mb;
  logic [24:0]       r_q;      // quotient without its leading 1: frac[22:0], guard, round
  logic signed [9:0] r_exp;
  logic              r_sign;
  logic [2:0]        r_spec;
  logic              r_busy;
  logic              r_done;
  logic [31:0]       r_z;
  logic [7:0]        r_status;

  // Operand classification (exponent 0 covers both zero and denormal)
  logic w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  assign w_a_zero = (a[30:23] == 8'h00);
  assign w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign w_b_zero = (b[30:23] == 8'h00);
  assign w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

  // Mantissa pre-alignment so the quotient always lies in [1, 2)
  logic [23:0]       w_ma, w_mb;
  logic              w_adj;
  logic [24:0]       w_rem0;
  logic signed [9:0] w_exp0;
  assign w_ma   = {1'b1, a[22:0]};
  assign w_mb   = {1'b1, b[22:0]};
  assign w_adj  = (w_ma < w_mb);
  assign w_rem0 = w_adj ? {w_ma, 1'b0} : {1'b0, w_ma};
  assign w_exp0 = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127 - {9'd0, w_adj};

  // Special-case priority: NaN-producing, divide-by-zero, inf result, zero result
  logic [2:0] w_spec;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_spec = SP_NONE;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
      w_spec = SP_NAN;
    else if (w_b_zero && !w_a_inf)
      w_spec = SP_DBZ;
    else if (w_a_inf)
      w_spec = SP_INF;
    else if (w_b_inf || w_a_zero)
      w_spec = SP_ZERO;
  end

  // One restoring division step
  logic        w_ge;
  logic [24:0] w_diff;
  assign w_ge   = (r_rem >= {1'b0, r_mb});
  assign w_diff = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  // Rounding inputs
  logic w_lsb, w_guard, w_round, w_sticky, w_inexact;
  assign w_lsb     = r_q[2];
  assign w_guard   = r_q[1];
  assign w_round   = r_q[0];
  assign w_sticky  = (r_rem != 25'd0);
  assign w_inexact = w_guard | w_round | w_sticky;

  // Round-up decision and overflow-to-infinity choice for the configured mode
  logic w_inc, w_ovf_inf;
  always_comb begin
    w_inc     = 1'b0;
    w_ovf_inf = 1'b1;
    case (ROUND)
      IEEE_near: w_inc = w_guard & (w_round | w_sticky | w_lsb);
      IEEE_zero: begin w_inc = 1'b0; w_ovf_inf = 1'b0; end
      IEEE_pinf: begin w_inc = ~r_sign & w_inexact; w_ovf_inf = ~r_sign; end
      IEEE_ninf: begin w_inc = r_sign & w_inexact; w_ovf_inf = r_sign; end
      near_up:   w_inc = w_guard & (w_round | w_sticky | ~r_sign);
      away_zero: w_inc = w_inexact;
      default:   w_inc = 1'b0;
    endcase
  end

  // Fraction increment; a carry out means 1.11..1 rounded to 10.0 (fraction wraps to 0)
  logic [23:0]       w_fsum;
  logic signed [9:0] w_exp_fin;
  assign w_fsum    = {1'b0, r_q[24:2]} + {23'd0, w_inc};
  assign w_exp_fin = r_exp + {9'd0, w_fsum[23]};

  // Final result and status selection
  logic [31:0] w_z_nx;
  logic [7:0]  w_st_nx;
  always_comb begin
    w_z_nx  = 32'd0;
    w_st_nx = 8'd0;
    case (r_spec)
      SP_NAN:  begin w_z_nx = 32'h7FC0_0000;             w_st_nx = 8'h04; end
      SP_DBZ:  begin w_z_nx = {r_sign, 8'hFF, 23'd0};    w_st_nx = 8'h42; end
      SP_INF:  begin w_z_nx = {r_sign, 8'hFF, 23'd0};    w_st_nx = 8'h02; end
      SP_ZERO: begin w_z_nx = {r_sign, 31'd0};           w_st_nx = 8'h01; end
      default: begin
        if (w_exp_fin > 10'sd254) begin
          if (w_ovf_inf) begin
            w_z_nx  = {r_sign, 8'hFF, 23'd0};
            w_st_nx = 8'h32;
          end else begin
            w_z_nx  = {r_sign, 31'h7F7F_FFFF};
            w_st_nx = 8'h30;
          end
        end else if (w_exp_fin < 10'sd1) begin
          w_z_nx  = {r_sign, 31'd0};
          w_st_nx = 8'h29;
        end else begin
          w_z_nx  = {r_sign, w_exp_fin[7:0], w_fsum[22:0]};
          w_st_nx = {2'b00, w_inexact, 5'b00000};
        end
      end
    endcase
  end

  // Control FSM and datapath registers: accept, iterate 26 times, round and publish
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_rem    <= 25'd0;
      r_mb     <= 24'd0;
      r_q      <= 25'd0;
      r_exp    <= 10'sd0;
      r_sign   <= 1'b0;
      r_spec   <= SP_NONE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_z      <= 32'd0;
      r_status <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_DIV;
            r_busy  <= 1'b1;
            r_cnt   <= 5'd0;
            r_rem   <= w_rem0;
            r_mb    <= w_mb;
            r_q     <= 25'd0;
            r_exp   <= w_exp0;
            r_sign  <= a[31] ^ b[31];
            r_spec  <= w_spec;
          end
        end
        S_DIV: begin
          r_rem <= w_diff << 1;
          r_q   <= (r_q << 1) | {24'd0, w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd25) r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_z      <= w_z_nx;
          r_status <= w_st_nx;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign z      = r_z;
  assign status = r_status;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: one divider instance per rounding mode sharing the same
// stimulus; directed vectors, random operands against an integer-arithmetic
// reference model, a held-start handshake sequence and a mid-division reset.

module tb_fp_div_seq;
  import fp_div_pkg::*;

  localparam int NM = 6;  // modes in enum order: near, zero, pinf, ninf, near_up, away

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy   [NM];
  logic        done   [NM];
  logic [31:0] z      [NM];
  logic [7:0]  status [NM];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NM; g++) begin : g_dut
    fp_div_seq #(.ROUND(round_values'(g))) u_dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy[g]), .done(done[g]), .z(z[g]), .status(status[g])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  // Reference: exact integer quotient with 32 extra fraction bits, then rounding by mode.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input int mode,
                                output logic [31:0] rz, output logic [7:0] rs);
    int ex, ey, e, k;
    bit zx, zy, ix, iy, nx, ny, sgn, inexact, above, tie, up, to_inf;
    longint unsigned ma, mb, num, qq, drem, mant, below, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    sgn = x[31] ^ y[31];
    if (nx || ny || (zx && zy) || (ix && iy)) begin rz = 32'h7FC00000; rs = 8'h04; return; end
    if (zy && !ix) begin rz = {sgn, 8'hFF, 23'd0}; rs = 8'h42; return; end
    if (ix)        begin rz = {sgn, 8'hFF, 23'd0}; rs = 8'h02; return; end
    if (iy || zx)  begin rz = {sgn, 31'd0};        rs = 8'h01; return; end
    ma   = {40'd1, x[22:0]};
    mb   = {40'd1, y[22:0]};
    num  = ma << 32;
    qq   = num / mb;
    drem = num % mb;
    e = ex - ey + 127;
    if (qq >= (64'd1 << 32)) k = 9;
    else begin k = 8; e = e - 1; end
    mant    = qq >> k;
    below   = qq & ((64'd1 << k) - 1);
    half    = 64'd1 << (k - 1);
    inexact = (below != 0) || (drem != 0);
    above   = (below > half) || ((below == half) && (drem != 0));
    tie     = (below == half) && (drem == 0);
    case (mode)
      0:       up = above || (tie && mant[0]);
      1:       up = 1'b0;
      2:       up = !sgn && inexact;
      3:       up = sgn && inexact;
      4:       up = above || (tie && !sgn);
      default: up = inexact;
    endcase
    mant = mant + (up ? 64'd1 : 64'd0);
    if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e = e + 1; end
    if (e > 254) begin
      to_inf = (mode == 0) || (mode == 4) || (mode == 5) || (mode == 2 && !sgn) || (mode == 3 && sgn);
      if (to_inf) begin rz = {sgn, 8'hFF, 23'd0}; rs = 8'h32; end
      else        begin rz = {sgn, 31'h7F7FFFFF}; rs = 8'h30; end
    end else if (e < 1) begin
      rz = {sgn, 31'd0};
      rs = 8'h29;
    end else begin
      rz = {sgn, e[7:0], mant[22:0]};
      rs = inexact ? 8'h20 : 8'h00;
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int sel;
    sel = $urandom_range(0, 9);
    v = $urandom;
    if (sel < 5)       v[30:23] = 8'($urandom_range(96, 160));
    else if (sel == 5) begin
      v[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 1) != 0) v[22:0] = 23'd0;
    end
    else if (sel == 6) v[30:23] = 8'($urandom_range(1, 20));
    else if (sel == 7) v[30:23] = 8'($urandom_range(235, 254));
    return v;
  endfunction

  // Issue one operation, scramble the operand inputs after accept, wait (bounded) for done.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, output int lat);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    check("busy_after_accept", 32'(busy[0]), 32'd1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done[0]) break;
    end
    check("latency", lat, 27);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done[0]), 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          mode;
    logic [31:0] z;
    logic [7:0]  st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [31:0] va, logic [31:0] vb, int m, logic [31:0] vz, logic [7:0] vs);
    vec_t v;
    v.a = va; v.b = vb; v.mode = m; v.z = vz; v.st = vs;
    vecs.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, cyc, ndone, d1, d2;
    logic [31:0] x, y, ez;
    logic [7:0]  es;

    add(32'h40C00000, 32'h40000000, 0, 32'h40400000, 8'h00);  // 6/2
    add(32'h3F800000, 32'h40400000, 0, 32'h3EAAAAAB, 8'h20);  // 1/3
    add(32'h3F800000, 32'h40400000, 1, 32'h3EAAAAAA, 8'h20);
    add(32'h3F800000, 32'h40400000, 2, 32'h3EAAAAAB, 8'h20);
    add(32'h3F800000, 32'h40400000, 5, 32'h3EAAAAAB, 8'h20);
    add(32'hBF800000, 32'h40400000, 2, 32'hBEAAAAAA, 8'h20);  // -1/3
    add(32'hBF800000, 32'h40400000, 3, 32'hBEAAAAAB, 8'h20);
    add(32'h3F800000, 32'h00000000, 0, 32'h7F800000, 8'h42);  // 1/0
    add(32'h00000000, 32'h00000000, 0, 32'h7FC00000, 8'h04);  // 0/0
    add(32'h3F800000, 32'h7F800000, 0, 32'h00000000, 8'h01);  // 1/inf
    add(32'h7F7FFFFF, 32'h3F000000, 0, 32'h7F800000, 8'h32);  // overflow
    add(32'h7F7FFFFF, 32'h3F000000, 1, 32'h7F7FFFFF, 8'h30);
    add(32'hFF7FFFFF, 32'h3F000000, 2, 32'hFF7FFFFF, 8'h30);
    add(32'hFF7FFFFF, 32'h3F000000, 3, 32'hFF800000, 8'h32);
    add(32'h00800000, 32'h40000000, 0, 32'h00000000, 8'h29);  // underflow
    add(32'h01000000, 32'h40000000, 0, 32'h00800000, 8'h00);  // smallest normal result
    add(32'h7F7FFFFF, 32'h3F800000, 0, 32'h7F7FFFFF, 8'h00);  // largest normal result
    add(32'h7F800000, 32'h40000000, 0, 32'h7F800000, 8'h02);  // inf/2
    add(32'h7F800000, 32'h00000000, 0, 32'h7F800000, 8'h02);  // inf/0
    add(32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 8'h04);  // NaN/1
    add(32'h80000000, 32'h7FC00000, 0, 32'h7FC00000, 8'h04);  // -0/NaN
    add(32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 8'h04);  // inf/-inf
    add(32'hBF800000, 32'h00000000, 0, 32'hFF800000, 8'h42);  // -1/0
    add(32'h00000000, 32'hFF800000, 0, 32'h80000000, 8'h01);  // 0/-inf
    add(32'h00000001, 32'h3F800000, 0, 32'h00000000, 8'h01);  // denormal dividend
    add(32'h3F800000, 32'h00000001, 0, 32'h7F800000, 8'h42);  // denormal divisor

    rst = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   32'(busy[0]),   32'd0);
    check("reset_done",   32'(done[0]),   32'd0);
    check("reset_z",      z[0],           32'd0);
    check("reset_status", 32'(status[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_z", i),      z[vecs[i].mode],           vecs[i].z);
      check($sformatf("vec%0d_status", i), 32'(status[vecs[i].mode]), 32'(vecs[i].st));
    end

    for (int n = 0; n < 150; n++) begin
      x = rand_fp();
      y = rand_fp();
      run_op(x, y, lat);
      for (int m = 0; m < NM; m++) begin
        model(x, y, m, ez, es);
        check($sformatf("rand a=%h b=%h m=%0d z", x, y, m),  z[m],           ez);
        check($sformatf("rand a=%h b=%h m=%0d st", x, y, m), 32'(status[m]), 32'(es));
      end
    end

    // start held high: accept at E0, ignore while busy, re-accept during the done cycle
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    cyc = 0; ndone = 0; d1 = 0; d2 = 0;
    while (ndone < 2 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5)  begin a = 32'h3F800000; b = 32'h40400000; end
      if (cyc == 14) check("hs_busy_mid", 32'(busy[0]), 32'd1);
      if (cyc == 28) check("hs_busy_reaccept", 32'(busy[0]), 32'd1);
      if (cyc == 40) begin a = 32'h12345678; b = 32'h40000000; end
      if (done[0]) begin
        ndone++;
        if (ndone == 1) begin d1 = cyc; check("hs_z1", z[0], 32'h40400000); end
        else            begin d2 = cyc; check("hs_z2", z[0], 32'h3EAAAAAB); end
      end
    end
    start = 1'b0;
    check("hs_done1_cycle", d1, 27);
    check("hs_done2_cycle", d2, 55);
    @(posedge clk); #1;
    check("hs_idle_after_release", 32'(busy[0]), 32'd0);

    // reset asserted at E10 of an operation
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_busy",   32'(busy[0]),   32'd0);
    check("rst_done",   32'(done[0]),   32'd0);
    check("rst_z",      z[0],           32'd0);
    check("rst_status", 32'(status[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(32'h40C00000, 32'h40000000, lat);
    check("post_rst_z",      z[0],           32'h40400000);
    check("post_rst_status", 32'(status[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
